// File: rtl/sc_obc_ddr_pkg.sv
// Shared types for the OBC DDR command-port arbiters: FSM encoding, default
// command field widths and the requester-ID width helper.
package sc_obc_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 40;
  localparam int DEF_LEN_W  = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: zero latency, no backpressure.
// The search starts at ptr and wraps, so req[ptr] has the highest priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan from the farthest offset down so the nearest request to ptr is kept.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % N)]) begin
        vld = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin owner of the single DDR command port; all outputs registered, grant 1 cycle after request.
// Command held stable under M_CMD_READY backpressure; ownership ends on M_DONE or watchdog expiry.
module ddr_port_arbiter
  import sc_obc_ddr_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ-1:0]        REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*LEN_W-1:0]  REQ_LEN,
  output logic [NUM_REQ-1:0]        REQ_ACCEPT,
  output logic [NUM_REQ-1:0]        REQ_GRANT,
  output logic [NUM_REQ-1:0]        REQ_DONE,
  output logic [NUM_REQ-1:0]        REQ_ERR,
  output logic                      M_CMD_VALID,
  input  logic                      M_CMD_READY,
  output logic                      M_CMD_WRITE,
  output logic [ADDR_W-1:0]         M_CMD_ADDR,
  output logic [LEN_W-1:0]          M_CMD_LEN,
  output logic [id_w(NUM_REQ)-1:0]  M_CMD_ID,
  input  logic                      M_DONE,
  output logic                      TIMEOUT_IRQ,
  input  logic                      IRQ_CLR,
  output logic                      BUSY
);

  localparam int IW = id_w(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, pick_idx;
  logic          pick_vld;
  logic [TW-1:0] timer;
  cmd_t          cmd_arr [NUM_REQ];
  cmd_t          pick_cmd;
  logic          do_grant, do_accept, do_done, do_err;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_arr[g] = {REQ_WRITE[g], REQ_ADDR[g*ADDR_W +: ADDR_W], REQ_LEN[g*LEN_W +: LEN_W]};
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req (REQ_VALID),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign pick_cmd = cmd_arr[pick_idx];
  assign ptr_nxt  = (M_CMD_ID == IW'(NUM_REQ - 1)) ? '0 : M_CMD_ID + IW'(1);

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Completion is checked before expiry so a same-cycle M_DONE suppresses the error.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_accept = 1'b0;
    do_done   = 1'b0;
    do_err    = 1'b0;
    case (state)
      ST_IDLE: if (pick_vld) begin
        do_grant  = 1'b1;
        state_nxt = ST_CMD;
      end
      ST_CMD: if (M_CMD_VALID && M_CMD_READY) begin
        do_accept = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (M_DONE) begin
          do_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          do_err    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      timer       <= '0;
      REQ_ACCEPT  <= '0;
      REQ_GRANT   <= '0;
      REQ_DONE    <= '0;
      REQ_ERR     <= '0;
      M_CMD_VALID <= 1'b0;
      M_CMD_WRITE <= 1'b0;
      M_CMD_ADDR  <= '0;
      M_CMD_LEN   <= '0;
      M_CMD_ID    <= '0;
      TIMEOUT_IRQ <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state      <= state_nxt;
      BUSY       <= (state_nxt != ST_IDLE);
      REQ_ACCEPT <= '0;
      REQ_DONE   <= '0;
      REQ_ERR    <= '0;

      if (do_grant) begin
        REQ_GRANT   <= onehot(pick_idx);
        M_CMD_VALID <= 1'b1;
        M_CMD_WRITE <= pick_cmd.write;
        M_CMD_ADDR  <= pick_cmd.addr;
        M_CMD_LEN   <= pick_cmd.len;
        M_CMD_ID    <= pick_idx;
      end

      if (do_accept) begin
        M_CMD_VALID <= 1'b0;
        REQ_ACCEPT  <= onehot(M_CMD_ID);
        timer       <= '0;
      end else if (state == ST_WAIT && timer != '1) begin
        timer <= timer + TW'(1);
      end

      if (do_done || do_err) begin
        REQ_GRANT <= '0;
        ptr       <= ptr_nxt;
      end
      if (do_done) REQ_DONE <= onehot(M_CMD_ID);
      if (do_err)  REQ_ERR  <= onehot(M_CMD_ID);

      if (do_err)       TIMEOUT_IRQ <= 1'b1;
      else if (IRQ_CLR) TIMEOUT_IRQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed + randomized bench for ddr_port_arbiter against a transaction-level round-robin model.
module tb_ddr_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 40;
  localparam int LW = 8;
  localparam int T  = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_VALID, REQ_WRITE;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*LW-1:0] REQ_LEN;
  logic [N-1:0]    REQ_ACCEPT, REQ_GRANT, REQ_DONE, REQ_ERR;
  logic            M_CMD_VALID, M_CMD_READY, M_CMD_WRITE;
  logic [AW-1:0]   M_CMD_ADDR;
  logic [LW-1:0]   M_CMD_LEN;
  logic [1:0]      M_CMD_ID;
  logic            M_DONE, TIMEOUT_IRQ, IRQ_CLR, BUSY;

  logic [AW-1:0]   req_addr [N];
  logic [LW-1:0]   req_len  [N];

  int vectors    = 0;
  int miscompares = 0;
  int exp_ptr    = 0;
  bit exp_irq    = 0;

  ddr_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .REQ_ACCEPT(REQ_ACCEPT), .REQ_GRANT(REQ_GRANT), .REQ_DONE(REQ_DONE), .REQ_ERR(REQ_ERR),
    .M_CMD_VALID(M_CMD_VALID), .M_CMD_READY(M_CMD_READY), .M_CMD_WRITE(M_CMD_WRITE),
    .M_CMD_ADDR(M_CMD_ADDR), .M_CMD_LEN(M_CMD_LEN), .M_CMD_ID(M_CMD_ID),
    .M_DONE(M_DONE), .TIMEOUT_IRQ(TIMEOUT_IRQ), .IRQ_CLR(IRQ_CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign REQ_ADDR[g*AW +: AW] = req_addr[g];
    assign REQ_LEN[g*LW +: LW]  = req_len[g];
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Round-robin rule: first pending requester at or after exp_ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(exp_ptr + i) % N]) return (exp_ptr + i) % N;
    return 0;
  endfunction

  task automatic rand_cmds();
    for (int i = 0; i < N; i++) begin
      req_addr[i] = AW'({$urandom(), $urandom()});
      req_len[i]  = LW'($urandom());
    end
    REQ_WRITE = N'($urandom());
  endtask

  task automatic check_zero(input string p);
    chk({p, "_grant"}, REQ_GRANT, 0);
    chk({p, "_accept"}, REQ_ACCEPT, 0);
    chk({p, "_done"}, REQ_DONE, 0);
    chk({p, "_err"}, REQ_ERR, 0);
    chk({p, "_valid"}, M_CMD_VALID, 0);
    chk({p, "_write"}, M_CMD_WRITE, 0);
    chk({p, "_addr"}, M_CMD_ADDR, 0);
    chk({p, "_len"}, M_CMD_LEN, 0);
    chk({p, "_id"}, M_CMD_ID, 0);
    chk({p, "_irq"}, TIMEOUT_IRQ, 0);
    chk({p, "_busy"}, BUSY, 0);
  endtask

  // Starts in an idle cycle with REQ_VALID nonzero. done_dly counts cycles from the
  // ACCEPT cycle to the M_DONE cycle; done_dly >= T means no completion (watchdog).
  task automatic run_txn(input int ready_dly, input int done_dly, input bit keep_req,
                         input bit clr_at_exp);
    int            w;
    logic [N-1:0]  oh;
    logic [AW-1:0] ea;
    logic [LW-1:0] el;
    logic          ew;
    bit            got_done, got_err;
    chk("idle_grant", REQ_GRANT, 0);
    chk("idle_busy", BUSY, 0);
    w  = model_pick(REQ_VALID);
    oh = N'(1) << w;
    ea = req_addr[w];
    el = req_len[w];
    ew = REQ_WRITE[w];
    M_DONE = 1'($urandom_range(0, 1));
    tick();
    chk("grant", REQ_GRANT, oh);
    chk("cmd_valid", M_CMD_VALID, 1);
    chk("cmd_id", M_CMD_ID, w);
    chk("cmd_addr", M_CMD_ADDR, ea);
    chk("cmd_len", M_CMD_LEN, el);
    chk("cmd_write", M_CMD_WRITE, ew);
    chk("busy_cmd", BUSY, 1);
    for (int i = 0; i < ready_dly; i++) begin
      REQ_VALID = (REQ_VALID & oh) | (N'($urandom()) & ~oh);
      M_DONE    = 1'($urandom_range(0, 1));
      tick();
      chk("bp_valid", M_CMD_VALID, 1);
      chk("bp_addr", M_CMD_ADDR, ea);
      chk("bp_len", M_CMD_LEN, el);
      chk("bp_id", M_CMD_ID, w);
      chk("bp_accept", REQ_ACCEPT, 0);
      chk("bp_done", REQ_DONE, 0);
    end
    M_CMD_READY = 1'b1;
    M_DONE      = 1'($urandom_range(0, 1));
    tick();
    M_CMD_READY = 1'b0;
    chk("accept", REQ_ACCEPT, oh);
    chk("valid_drop", M_CMD_VALID, 0);
    chk("accept_done", REQ_DONE, 0);
    chk("grant_held", REQ_GRANT, oh);
    if (!keep_req) REQ_VALID[w] = 1'b0;
    for (int k = 0; k < T; k++) begin
      M_DONE   = (k == done_dly);
      IRQ_CLR  = clr_at_exp && (k == T - 1);
      got_done = (k == done_dly);
      got_err  = !got_done && (k == T - 1);
      tick();
      M_DONE  = 1'b0;
      IRQ_CLR = 1'b0;
      if (got_err) exp_irq = 1'b1;
      else if (clr_at_exp && k == T - 1) exp_irq = 1'b0;
      chk("done", REQ_DONE, got_done ? oh : '0);
      chk("err", REQ_ERR, got_err ? oh : '0);
      chk("irq", TIMEOUT_IRQ, exp_irq);
      chk("grant_wait", REQ_GRANT, (got_done || got_err) ? '0 : oh);
      chk("busy_wait", BUSY, !(got_done || got_err));
      chk("accept_wait", REQ_ACCEPT, 0);
      if (got_done || got_err) begin
        exp_ptr = (w + 1) % N;
        break;
      end
    end
  endtask

  task automatic clr_irq();
    REQ_VALID = '0;
    IRQ_CLR   = 1'b1;
    tick();
    IRQ_CLR = 1'b0;
    exp_irq = 1'b0;
    chk("irq_clr", TIMEOUT_IRQ, 0);
    chk("irq_clr_busy", BUSY, 0);
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = '0; REQ_WRITE = '0;
    M_CMD_READY = 1'b0; M_DONE = 1'b0; IRQ_CLR = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0;
      req_len[i]  = '0;
    end
    tick();
    tick();
    check_zero("reset");

    // Single requester 2: write, addr 0x1000, len 15
    RST = 1'b0;
    req_addr[2] = 40'h1000;
    req_len[2]  = 8'd15;
    REQ_WRITE   = 4'b0100;
    REQ_VALID   = 4'b0100;
    run_txn(2, 3, 0, 0);

    // All four requesting from ptr 0, immediate READY and DONE
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_ptr = 0;
    exp_irq = 0;
    rand_cmds();
    REQ_VALID = 4'b1111;
    repeat (5) run_txn(0, 0, 1, 0);

    // Backpressure for 10 cycles
    rand_cmds();
    REQ_VALID = N'($urandom_range(1, (1 << N) - 1));
    run_txn(10, $urandom_range(0, 5), 0, 0);

    // Watchdog expiry, then clear
    rand_cmds();
    REQ_VALID = N'($urandom_range(1, (1 << N) - 1));
    run_txn(0, T + 4, 0, 0);
    clr_irq();

    // Completion on the expiry cycle wins
    rand_cmds();
    REQ_VALID = N'($urandom_range(1, (1 << N) - 1));
    run_txn(1, T - 1, 0, 0);

    // IRQ_CLR coincident with a new timeout leaves IRQ set
    REQ_VALID = N'($urandom_range(1, (1 << N) - 1));
    run_txn(0, T + 2, 0, 0);
    REQ_VALID = N'($urandom_range(1, (1 << N) - 1));
    run_txn(0, T + 2, 0, 1);
    clr_irq();

    // Randomized mix
    for (int n = 0; n < 20; n++) begin
      rand_cmds();
      REQ_VALID = N'($urandom_range(1, (1 << N) - 1));
      run_txn($urandom_range(0, 3), $urandom_range(0, T + 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while requester 1 owns the port in WAIT
    REQ_VALID = 4'b0001;
    run_txn(0, T + 4, 0, 0);
    REQ_VALID = 4'b0010;
    tick();
    chk("abort_grant", REQ_GRANT, 4'b0010);
    M_CMD_READY = 1'b1;
    tick();
    M_CMD_READY = 1'b0;
    chk("abort_accept", REQ_ACCEPT, 4'b0010);
    repeat (3) tick();
    chk("abort_busy", BUSY, 1);
    RST    = 1'b1;
    M_DONE = 1'b1;
    tick();
    check_zero("wait_rst");
    tick();
    check_zero("wait_rst2");
    RST     = 1'b0;
    M_DONE  = 1'b0;
    exp_ptr = 0;
    exp_irq = 0;
    REQ_VALID = 4'b1111;
    run_txn(0, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Round-robin arbiter that shares the single DDR4 command port of the Versal PS/NoC memory path between up to NUM_REQ fabric requesters. Each requester submits a burst command (read/write, address, length). The arbiter forwards one command at a time downstream and holds ownership until the memory side reports completion or a watchdog expires. It sits between the fabric DMA/logic masters and the AXI-to-NoC bridge feeding the DDR4 controller, and its GRANT vector drives the external data-path mux.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 40, command address width
- LEN_W, 8, burst length field width (beats minus 1)
- TIMEOUT_CYCLES, 4096, completion watchdog limit (≥2)

- CLK  in  1  sole clock
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  NUM_REQ  per-requester command pending; held until REQ_ACCEPT
- REQ_WRITE  in  NUM_REQ  1 = write, 0 = read
- REQ_ADDR  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- REQ_LEN  in  NUM_REQ*LEN_W  packed lengths
- REQ_ACCEPT  out  NUM_REQ  one-cycle pulse: command taken downstream
- REQ_GRANT  out  NUM_REQ  one-hot owner of data path, else 0
- REQ_DONE  out  NUM_REQ  one-cycle pulse: transaction complete
- REQ_ERR  out  NUM_REQ  one-cycle pulse: watchdog expired
- M_CMD_VALID  out  1  downstream command valid
- M_CMD_READY  in  1  downstream ready
- M_CMD_WRITE / M_CMD_ADDR / M_CMD_LEN  out  1/ADDR_W/LEN_W  registered copy of winner's command
- M_CMD_ID  out  clog2(NUM_REQ)  winner index
- M_DONE  in  1  completion pulse from memory side
- TIMEOUT_IRQ  out  1  sticky timeout flag
- IRQ_CLR  in  1  clears TIMEOUT_IRQ
- BUSY  out  1  state ≠ IDLE

## Operation
- States: IDLE, CMD, WAIT.
- IDLE: if any REQ_VALID, select winner by round-robin. Search starts at index ptr and wraps, so ptr has the highest priority. Latch the winner's command into M_CMD_*, set REQ_GRANT one-hot, go to CMD.
- CMD: M_CMD_VALID=1. On M_CMD_VALID&&M_CMD_READY: pulse REQ_ACCEPT[winner] next cycle, clear timer, go to WAIT. M_CMD_* stays stable while VALID&&!READY.
- WAIT: timer increments each cycle.
  - M_DONE: pulse REQ_DONE[winner], drop GRANT, set ptr=(winner+1) mod NUM_REQ, go to IDLE.
  - Timer == TIMEOUT_CYCLES-1 without M_DONE: pulse REQ_ERR[winner], set TIMEOUT_IRQ, drop GRANT, advance ptr, go to IDLE.
- Boundary rules:
  - M_DONE in the same cycle as expiry: completion wins, with no ERR and no IRQ.
  - M_DONE in IDLE or CMD: ignored.
  - IRQ_CLR coincident with a new timeout: set wins.
  - REQ_VALID dropped by the owner after grant: does not affect the transaction.
  - REQ_VALID of a non-owner: ignored until IDLE.
  - Timer saturates; it does not wrap.
- Reset: state IDLE, ptr 0, timer 0. All outputs 0, including M_CMD_ADDR/LEN/WRITE/ID, GRANT, pulses, IRQ and BUSY. RST mid-transaction abandons it with no DONE/ERR pulse.

## Timing
- All outputs registered.
- REQ_VALID sampled at cycle t in IDLE → REQ_GRANT and M_CMD_VALID high at t+1.
- Handshake at cycle h → REQ_ACCEPT at h+1, M_CMD_VALID low at h+1.
- M_DONE at cycle d → REQ_DONE pulse and GRANT low at d+1, IDLE at d+1. The next grant can appear at d+2, giving a minimum 1-cycle gap between owners.
- Timeout: ERR pulse exactly TIMEOUT_CYCLES cycles after REQ_ACCEPT.
- Minimum per-transaction overhead: 3 cycles plus downstream latency.

## Structure
- Shared package sc_obc_ddr_pkg holds:
  - state encoding (IDLE=0, CMD=1, WAIT=2)
  - command field widths
  - the ID width function
- One natural sub-module: rr_pick. This is a combinational round-robin priority encoder taking the request vector and ptr and returning a valid flag and the winner index, so it can be reused by other OBC arbiters.

## Test plan
- Single requester: REQ_VALID[2]=1, addr 0x1000, len 15, write. → GRANT=0b0100 at t+1, M_CMD_ID=2, ACCEPT after READY, DONE the cycle after M_DONE.
- All four requesting continuously with ptr=0 and immediate READY/DONE. → Grant order 0,1,2,3,0, with a one-cycle IDLE gap each time.
- Backpressure: M_CMD_READY low for 10 cycles. → M_CMD_* stable throughout, no ACCEPT until READY.
- Watchdog with TIMEOUT_CYCLES=16 and no M_DONE. → REQ_ERR pulse 16 cycles after ACCEPT, TIMEOUT_IRQ=1 until IRQ_CLR, ptr advanced.
- M_DONE on the expiry cycle. → DONE only, IRQ stays 0. Also check IRQ_CLR coincident with a new timeout leaves IRQ=1.
- RST asserted in WAIT. → All outputs 0 next cycle, no DONE/ERR, the next arbitration starts from requester 0.
